// File: rtl/sqrt2_if.sv
// Handshake and status signals of the binary16 square-root peripheral.
// The shared tri-state data bus stays a plain inout net on the block.
interface sqrt2_if;
  logic enable;
  logic result;
  logic is_nan;
  logic is_pinf;
  logic is_ninf;

  modport master (output enable, input result, is_nan, is_pinf, is_ninf);
  modport slave  (input enable, output result, is_nan, is_pinf, is_ninf);
endinterface

// File: rtl/sqrt2.sv
// Multi-cycle IEEE-754 binary16 square root with truncating rounding.
// The operand and the result share one 16-bit tri-state bus.
module sqrt2 (
  input  logic       clk,
  input  logic       rst_n,
  sqrt2_if.slave     bus,
  inout  wire [15:0] io_data
);
  typedef enum logic [1:0] {IDLE, NORM, CALC, DONE} state_t;

  state_t state, state_nxt;
  logic [15:0] x_q, dout_q;
  logic        nan_q, pinf_q;
  logic [21:0] rad_q;
  logic [13:0] rem_q;
  logic [10:0] root_q;
  logic [3:0]  cnt_q;
  logic [4:0]  exp_q;
  logic        done;

  // special-operand classification of the latched operand
  logic        special, spec_nan, spec_pinf;
  logic [15:0] spec_val;
  always_comb begin
    special   = 1'b1;
    spec_val  = x_q;
    spec_nan  = 1'b0;
    spec_pinf = 1'b0;
    if (x_q[14:10] == 5'h1f && x_q[9:0] != 10'd0) begin
      spec_val = x_q | 16'h0200;
      spec_nan = 1'b1;
    end else if (x_q[14:0] == 15'd0) begin
      spec_val = x_q;
    end else if (x_q[15]) begin
      spec_val = 16'hfe00;
      spec_nan = 1'b1;
    end else if (x_q[14:10] == 5'h1f) begin
      spec_pinf = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // normalize to a leading one and make the exponent even
  logic [3:0]        sh;
  logic [10:0]       m11;
  logic [11:0]       m_n;
  logic signed [6:0] e_raw, e_even;
  logic [4:0]        exp_n;
  always_comb begin
    sh = 4'd0;
    for (int i = 0; i < 10; i++)
      if (x_q[i]) sh = 4'(10 - i);
    if (x_q[14:10] == 5'd0) begin
      m11   = {1'b0, x_q[9:0]} << sh;
      e_raw = -7'sd14 - $signed({3'b000, sh});
    end else begin
      m11   = {1'b1, x_q[9:0]};
      e_raw = $signed({2'b00, x_q[14:10]}) - 7'sd15;
    end
    if (e_raw[0]) begin
      m_n    = {m11, 1'b0};
      e_even = e_raw - 7'sd1;
    end else begin
      m_n    = {1'b0, m11};
      e_even = e_raw;
    end
    exp_n = 5'((e_even >>> 1) + 7'sd15);
  end

  // one restoring root digit per cycle
  logic [15:0] t, trial;
  logic        ge;
  assign t     = {rem_q, rad_q[21:20]};
  assign trial = {3'b000, root_q, 2'b01};
  assign ge    = (t >= trial);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.enable) state_nxt = NORM;
      NORM: if (!bus.enable) state_nxt = IDLE;
            else if (special) state_nxt = DONE;
            else state_nxt = CALC;
      CALC: if (!bus.enable) state_nxt = IDLE;
            else if (cnt_q == 4'd11) state_nxt = DONE;
      DONE: if (!bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      dout_q <= '0;
      nan_q  <= 1'b0;
      pinf_q <= 1'b0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.enable) x_q <= io_data;
        NORM: begin
          nan_q  <= spec_nan;
          pinf_q <= spec_pinf;
          dout_q <= spec_val;
          rad_q  <= {m_n, 10'd0};
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
          exp_q  <= exp_n;
        end
        CALC: begin
          if (cnt_q != 4'd11) begin
            rad_q  <= rad_q << 2;
            rem_q  <= ge ? 14'(t - trial) : t[13:0];
            root_q <= {root_q[9:0], ge};
            cnt_q  <= cnt_q + 4'd1;
          end else begin
            dout_q <= {1'b0, exp_q, root_q[9:0]};
          end
        end
        default: ;
      endcase
    end
  end

  // outputs and bus drive follow the DONE state so reset releases them at once
  assign done        = (state == DONE);
  assign bus.result  = done;
  assign bus.is_nan  = done & nan_q;
  assign bus.is_pinf = done & pinf_q;
  assign bus.is_ninf = 1'b0;
  assign io_data     = done ? dout_q : 16'hzzzz;
endmodule

// File: tb/tb_sqrt2.sv
// Randomized and directed bench for sqrt2 against a real-arithmetic model.
// A weak pull-up on the bus makes an undriven bus read as 16'hFFFF.
module tb_sqrt2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drv_oe = 1'b0;
  logic [15:0] drv_val = '0;
  tri1 [15:0] io_data;
  assign io_data = drv_oe ? drv_val : 16'hzzzz;

  sqrt2_if bus ();
  sqrt2 dut (.clk(clk), .rst_n(rst_n), .bus(bus), .io_data(io_data));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_r;
  logic        m_n, m_p;
  int          m_lat;
  logic [15:0] r_d;
  logic        r_n, r_p, r_ni, r_early, r_held, r_rel;
  int          r_lat;

  // value-level model: decode to a real, take sqrt, truncate to binary16
  task automatic model(input logic [15:0] x);
    real v, y;
    int  k, e;
    m_n = 1'b0; m_p = 1'b0; m_lat = 1;
    if (x[14:10] == 5'h1f && x[9:0] != 0) begin m_r = x | 16'h0200; m_n = 1'b1; end
    else if (x[14:0] == 0) m_r = x;
    else if (x[15]) begin m_r = 16'hfe00; m_n = 1'b1; end
    else if (x[14:10] == 5'h1f) begin m_r = 16'h7c00; m_p = 1'b1; end
    else begin
      m_lat = 13;
      if (x[14:10] == 0) begin v = real'(x[9:0]); k = -24; end
      else begin v = real'(1024 + int'(x[9:0])); k = int'(x[14:10]) - 25; end
      while (k < 0) begin v = v / 2.0; k++; end
      while (k > 0) begin v = v * 2.0; k--; end
      y = $sqrt(v);
      e = 0;
      while (y >= 2.0) begin y = y / 2.0; e++; end
      while (y < 1.0) begin y = y * 2.0; e--; end
      m_r = {1'b0, 5'(e + 15), 10'($rtoi((y - 1.0) * 1024.0))};
    end
  endtask

  task automatic do_op(input logic [15:0] x, input int hold);
    @(negedge clk);
    bus.enable = 1'b1; drv_oe = 1'b1; drv_val = x;
    @(posedge clk); #1 drv_oe = 1'b0;
    r_lat = -1; r_early = 1'b0; r_d = '0; r_n = 0; r_p = 0; r_ni = 0;
    for (int k = 1; k <= 20 && r_lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.result) begin
        r_lat = k; r_d = io_data; r_n = bus.is_nan; r_p = bus.is_pinf; r_ni = bus.is_ninf;
      end else if (io_data !== 16'hffff) r_early = 1'b1;
    end
    r_held = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (bus.result !== 1'b1 || io_data !== r_d || bus.is_nan !== r_n || bus.is_pinf !== r_p)
        r_held = 1'b0;
    end
    @(negedge clk) bus.enable = 1'b0;
    @(posedge clk); #1;
    r_rel = (bus.result === 1'b0) && (io_data === 16'hffff) &&
            (bus.is_nan === 1'b0) && (bus.is_pinf === 1'b0) && (bus.is_ninf === 1'b0);
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 1'b0 || bus.is_nan !== 1'b0 || bus.is_pinf !== 1'b0 ||
        bus.is_ninf !== 1'b0 || io_data !== 16'hffff) begin
      errors++;
      $display("FAIL reset_state: result=%b nan=%b pinf=%b ninf=%b io=%h, want 0 0 0 0 ffff",
               bus.result, bus.is_nan, bus.is_pinf, bus.is_ninf, io_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (bus.result !== 1'b0 || io_data !== 16'hffff) begin
      errors++;
      $display("FAIL idle_after_reset: result=%b io=%h, want 0 ffff", bus.result, io_data);
    end
  endtask

  logic [15:0] dir_x [15] = '{16'h3c00, 16'h4000, 16'h4200, 16'h4880, 16'h3e00, 16'h3555,
                              16'h3c80, 16'h7bff, 16'h0001, 16'h0010, 16'h03ff, 16'h0000,
                              16'h8000, 16'h7c00, 16'hfc00};
  logic [15:0] dir_r [15] = '{16'h3c00, 16'h3da8, 16'h3eed, 16'h4200, 16'h3ce6, 16'h389e,
                              16'h3c3e, 16'h5bff, 16'h0c00, 16'h1400, 16'h1ffe, 16'h0000,
                              16'h8000, 16'h7c00, 16'hfe00};
  logic [1:0]  dir_f [15] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  int          dir_l [15] = '{13, 13, 13, 13, 13, 13, 13, 13, 13, 13, 13, 1, 1, 1, 1};

  task automatic test_directed();
    for (int i = 0; i < 15; i++) begin
      do_op(dir_x[i], 0);
      checks++;
      if (r_d !== dir_r[i] || {r_n, r_p} !== dir_f[i] || r_ni !== 1'b0 || r_lat !== dir_l[i]) begin
        errors++;
        $display("FAIL directed x=%h: got %h nan=%b pinf=%b ninf=%b lat=%0d, want %h flags=%b lat=%0d",
                 dir_x[i], r_d, r_n, r_p, r_ni, r_lat, dir_r[i], dir_f[i], dir_l[i]);
      end
      checks++;
      if (r_early || !r_rel) begin
        errors++;
        $display("FAIL directed_bus x=%h: early_drive=%b released=%b, want 0 1", dir_x[i], r_early, r_rel);
      end
    end
  endtask

  logic [15:0] nan_x [5] = '{16'hc000, 16'hbc00, 16'hb800, 16'h7e00, 16'hfe00};
  logic [15:0] nan_r [5] = '{16'hfe00, 16'hfe00, 16'hfe00, 16'h7e00, 16'hfe00};

  task automatic test_negatives_nan();
    for (int i = 0; i < 5; i++) begin
      do_op(nan_x[i], 0);
      checks++;
      if (r_d !== nan_r[i] || r_n !== 1'b1 || r_p !== 1'b0 || r_lat !== 1) begin
        errors++;
        $display("FAIL nan x=%h: got %h nan=%b pinf=%b lat=%0d, want %h nan=1 pinf=0 lat=1",
                 nan_x[i], r_d, r_n, r_p, r_lat, nan_r[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x;
    for (int i = 0; i < 60; i++) begin
      x = 16'($urandom);
      if ($urandom_range(0, 3) != 0) x[15] = 1'b0;
      model(x);
      do_op(x, 0);
      checks++;
      if (r_d !== m_r || r_n !== m_n || r_p !== m_p || r_ni !== 1'b0 || r_lat !== m_lat || !r_rel) begin
        errors++;
        $display("FAIL random x=%h: got %h nan=%b pinf=%b lat=%0d rel=%b, want %h nan=%b pinf=%b lat=%0d",
                 x, r_d, r_n, r_p, r_lat, r_rel, m_r, m_n, m_p, m_lat);
      end
    end
  endtask

  task automatic test_hold_release();
    logic [15:0] hx [3] = '{16'h4880, 16'h7c00, 16'hc000};
    for (int i = 0; i < 3; i++) begin
      model(hx[i]);
      do_op(hx[i], 6);
      checks++;
      if (r_d !== m_r || !r_held || !r_rel) begin
        errors++;
        $display("FAIL hold x=%h: got %h held=%b released=%b, want %h 1 1", hx[i], r_d, r_held, r_rel, m_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    for (int i = 0; i < 8; i++) begin
      x = {1'b0, 15'($urandom)};
      model(x);
      do_op(x, 0);
      checks++;
      if (r_d !== m_r || r_n !== m_n || r_p !== m_p || r_lat !== m_lat) begin
        errors++;
        $display("FAIL back_to_back x=%h: got %h lat=%0d, want %h lat=%0d", x, r_d, r_lat, m_r, m_lat);
      end
    end
  endtask

  task automatic test_abort();
    logic seen;
    @(negedge clk);
    bus.enable = 1'b1; drv_oe = 1'b1; drv_val = 16'h4000;
    @(posedge clk); #1 drv_oe = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) bus.enable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.result !== 1'b0 || io_data !== 16'hffff) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_result: result or bus drive seen=%b, want 0", seen);
    end
    do_op(16'h4700, 0);
    checks++;
    if (r_d !== 16'h414a || r_lat !== 13) begin
      errors++;
      $display("FAIL abort_followup: got %h lat=%0d, want 414a lat=13", r_d, r_lat);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.enable = 1'b1; drv_oe = 1'b1; drv_val = 16'h4200;
    @(posedge clk); #1 drv_oe = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 1'b0 || io_data !== 16'hffff) begin
      errors++;
      $display("FAIL reset_mid_calc: result=%b io=%h, want 0 ffff", bus.result, io_data);
    end
    bus.enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    // reset while the result is on the bus releases it without waiting for a clock
    @(negedge clk);
    bus.enable = 1'b1; drv_oe = 1'b1; drv_val = 16'h0000;
    @(posedge clk); #1 drv_oe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.result !== 1'b1 || io_data !== 16'h0000) begin
      errors++;
      $display("FAIL zero_before_reset: result=%b io=%h, want 1 0000", bus.result, io_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 1'b0 || io_data !== 16'hffff) begin
      errors++;
      $display("FAIL reset_in_done: result=%b io=%h, want 0 ffff", bus.result, io_data);
    end
    bus.enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    do_op(16'h4880, 0);
    checks++;
    if (r_d !== 16'h4200 || r_lat !== 13) begin
      errors++;
      $display("FAIL after_reset_op: got %h lat=%0d, want 4200 lat=13", r_d, r_lat);
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_directed();
    test_negatives_nan();
    test_random();
    test_hold_release();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
